// File: rtl/fib_seq_if.sv
// Result stream from the recurrence engine: valid/ready beats carrying one term each.
interface fib_seq_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (output out_valid, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/fib_seq_engine.sv
// Generalised two-term recurrence engine T(k)=T(k-1)+T(k-2) with user seeds.
// Single-result mode returns T(n); stream mode emits T(0)..T(n) under backpressure.
module fib_seq_engine #(
    parameter int N_WIDTH   = 6,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_WIDTH-1:0]   n,
    input  logic [OUT_WIDTH-1:0] seed0,
    input  logic [OUT_WIDTH-1:0] seed1,
    input  logic                 stream,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    fib_seq_if.master            res
);
    typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;

    state_t               state;
    logic [OUT_WIDTH-1:0] a, b, data_q;
    logic [N_WIDTH-1:0]   idx, n_q;
    logic                 stream_q, valid_q, last_q, done_q, ovf_q;
    logic [OUT_WIDTH:0]   sum;
    logic [N_WIDTH-1:0]   idx_nxt;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign idx_nxt = idx + 1'b1;

    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign ovf           = ovf_q;
    assign res.out_valid = valid_q;
    assign res.out_data  = data_q;
    assign res.out_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            idx      <= '0;
            n_q      <= '0;
            stream_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a        <= seed0;
                        b        <= seed1;
                        n_q      <= n;
                        stream_q <= stream;
                        ovf_q    <= 1'b0;
                        if (stream) begin
                            // First beat T(0) is presented straight from the seed.
                            idx     <= '0;
                            state   <= OUT;
                            valid_q <= 1'b1;
                            data_q  <= seed0;
                            last_q  <= (n == '0);
                        end else begin
                            idx   <= {{(N_WIDTH-1){1'b0}}, 1'b1};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (n_q <= idx) begin
                        state   <= OUT;
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
                        data_q  <= (n_q == '0) ? a : b;
                    end else begin
                        a   <= b;
                        b   <= sum[OUT_WIDTH-1:0];
                        idx <= idx_nxt;
                        if (sum[OUT_WIDTH]) ovf_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (res.out_ready) begin
                        if (!stream_q || idx == n_q) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            a      <= b;
                            idx    <= idx_nxt;
                            data_q <= b;
                            last_q <= (idx_nxt == n_q);
                            // b already holds T(n) when idx_nxt==n; skip the add past it.
                            if (idx_nxt != n_q) begin
                                b <= sum[OUT_WIDTH-1:0];
                                if (sum[OUT_WIDTH]) ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine with an 8-bit datapath so wraparound is reachable.
module tb_fib_seq_engine;
    localparam int NW = 6;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stream = 1'b0;
    logic          abort = 1'b0;
    logic [NW-1:0] n = '0;
    logic [OW-1:0] seed0 = '0;
    logic [OW-1:0] seed1 = '0;
    logic          busy, done, ovf;
    int            checks = 0;
    int            fails = 0;

    fib_seq_if #(.OUT_WIDTH(OW)) bus ();

    fib_seq_engine #(.N_WIDTH(NW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .seed0(seed0), .seed1(seed1),
        .stream(stream), .abort(abort), .busy(busy), .done(done), .ovf(ovf), .res(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: T(k) modulo 2^OW from plain integer arithmetic.
    function automatic logic [OW-1:0] ref_term(input int s0, input int s1, input int k);
        longint t0 = s0, t1 = s1, t;
        if (k == 0) return OW'(t0);
        for (int i = 2; i <= k; i++) begin
            t  = (t0 + t1) % (longint'(1) << OW);
            t0 = t1;
            t1 = t;
        end
        return OW'(t1);
    endfunction

    // Reference: did any addition producing T(2)..T(k) exceed the datapath width.
    function automatic logic ref_ovf(input int s0, input int s1, input int k);
        longint t0 = s0, t1 = s1, t;
        logic o = 1'b0;
        for (int i = 2; i <= k; i++) begin
            t = t0 + t1;
            if (t >= (longint'(1) << OW)) o = 1'b1;
            t0 = t1;
            t1 = t % (longint'(1) << OW);
        end
        return o;
    endfunction

    task automatic do_start(input logic [OW-1:0] s0, input logic [OW-1:0] s1, input int nn, input logic str);
        seed0 = s0; seed1 = s1; n = NW'(nn); stream = str; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, ovf, bus.out_valid, bus.out_last, bus.out_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b valid=%b last=%b data=%0d, want all 0",
                     busy, done, ovf, bus.out_valid, bus.out_last, bus.out_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_single(input logic [OW-1:0] s0, input logic [OW-1:0] s1, input int nn, input bit poke);
        int lat = 0;
        int lat_exp = 1 + ((nn > 1) ? nn - 1 : 0);
        logic [OW-1:0] exp_d = ref_term(s0, s1, nn);
        bus.out_ready = 1'b1;
        do_start(s0, s1, nn, 1'b0);
        checks++;
        if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear_on_start: got %b want 0", ovf); end
        while (!bus.out_valid && lat < 200) begin
            if (poke) begin
                start = 1'($urandom_range(0, 1)); seed0 = OW'($urandom); seed1 = OW'($urandom);
                n = NW'($urandom); stream = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== lat_exp) begin fails++; $display("FAIL single_latency n=%0d: got %0d want %0d", nn, lat, lat_exp); end
        checks++;
        if (bus.out_data !== exp_d || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL single_result n=%0d: got data=%0d last=%b want data=%0d last=1", nn, bus.out_data, bus.out_last, exp_d);
        end
        tick();
        checks++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_done n=%0d: got done=%b valid=%b busy=%b want 1 0 1", nn, done, bus.out_valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ovf !== ref_ovf(s0, s1, nn)) begin
            fails++;
            $display("FAIL single_end n=%0d: got done=%b busy=%b ovf=%b want 0 0 %b", nn, done, busy, ovf, ref_ovf(s0, s1, nn));
        end
    endtask

    // mode 0: ready alternates 1,0,1,0...; mode 1: random ready
    task automatic test_stream(input logic [OW-1:0] s0, input logic [OW-1:0] s1, input int nn, input int mode);
        int got = 0, cyc = 0;
        bit stalled = 0, fin = 0;
        logic [OW-1:0] hd = '0;
        logic hl = 1'b0;
        do_start(s0, s1, nn, 1'b1);
        while (!fin && cyc < 400) begin
            bus.out_ready = (mode == 0) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            checks++;
            if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid beat %0d: got %b want 1", got, bus.out_valid); end
            if (stalled) begin
                checks++;
                if (bus.out_data !== hd || bus.out_last !== hl) begin
                    fails++;
                    $display("FAIL stream_hold beat %0d: got data=%0d last=%b want data=%0d last=%b", got, bus.out_data, bus.out_last, hd, hl);
                end
            end
            if (bus.out_ready) begin
                checks++;
                if (bus.out_data !== ref_term(s0, s1, got) || bus.out_last !== (got == nn)) begin
                    fails++;
                    $display("FAIL stream_beat %0d: got data=%0d last=%b want data=%0d last=%b",
                             got, bus.out_data, bus.out_last, ref_term(s0, s1, got), (got == nn));
                end
                got++;
                stalled = 0;
            end else begin
                stalled = 1; hd = bus.out_data; hl = bus.out_last;
            end
            tick();
            cyc++;
            if (got > nn) fin = 1;
        end
        bus.out_ready = 1'b1;
        checks++;
        if (!fin) begin fails++; $display("FAIL stream_timeout: got %0d beats want %0d", got, nn + 1); end
        checks++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL stream_done: got done=%b valid=%b want 1 0", done, bus.out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ovf !== ref_ovf(s0, s1, nn)) begin
            fails++;
            $display("FAIL stream_end: got done=%b busy=%b ovf=%b want 0 0 %b", done, busy, ovf, ref_ovf(s0, s1, nn));
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        bus.out_ready = 1'b1;
        do_start(8'd0, 8'd1, 40, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_calc: got busy=%b valid=%b want 0 0", busy, bus.out_valid);
        end
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid || done || busy) seen = 1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL abort_quiet: activity seen=%b want 0", seen); end
        // abort beats a same-cycle handshake
        do_start(8'd2, 8'd1, 5, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus.out_last !== 1'b0) begin
            fails++;
            $display("FAIL abort_handshake: got valid=%b done=%b busy=%b last=%b want 0 0 0 0", bus.out_valid, done, busy, bus.out_last);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b want 0", done); end
        // abort in IDLE does not block a start
        seed0 = 8'd9; seed1 = 8'd4; n = NW'(1); stream = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL abort_idle_start: busy=%b want 1", busy); end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle_drain: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        bus.out_ready = 1'b0;
        do_start(8'd3, 8'd7, 20, 1'b1);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.out_valid, bus.out_last, bus.out_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b valid=%b last=%b data=%0d want all 0",
                     busy, done, bus.out_valid, bus.out_last, bus.out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_idle: busy=%b want 0", busy); end
        test_single(8'd0, 8'd1, 10, 0);
        w = 0;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_single(8'd0, 8'd1, 10, 0);
        test_stream(8'd2, 8'd1, 5, 0);
        test_single(8'd0, 8'd1, 13, 0);
        test_single(8'd0, 8'd1, 14, 0);
        test_single(8'd0, 8'd1, 13, 0);
        test_single(8'd37, 8'd99, 0, 0);
        test_single(8'd37, 8'd99, 1, 0);
        test_single(8'd0, 8'd1, 10, 1);
        test_stream(8'd5, 8'd250, 0, 1);
        test_stream(8'd0, 8'd1, 14, 1);
        test_abort();
        test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                test_stream(OW'($urandom), OW'($urandom), $urandom_range(0, 24), 1);
            else
                test_single(OW'($urandom), OW'($urandom), $urandom_range(0, 30), 0);
        end
        test_single(8'd1, 8'd1, 63, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
